buffered_router: RTL and testbench
==================================

Name: buffered_router

Overview:
- Parametrised, clocked successor to the combinational 4-way router.
- Forwards each accepted input word to one of NUM_OUT output channels selected by addr.
- Each channel has its own FIFO of depth FIFO_DEPTH, so a stalled destination does not lose data.
- Sits between a single producer and NUM_OUT independent consumers; all ports use valid/ready handshakes.

Parameters:
DATA_WIDTH, 32, width of each data word
NUM_OUT, 4, number of output channels, 2..16
FIFO_DEPTH, 4, entries per output FIFO, power of two, >= 2
ADDR_WIDTH, $clog2(NUM_OUT), width of addr (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
din  input  DATA_WIDTH  input data word
din_valid  input  1  din/addr carry a word this cycle
din_ready  output  1  router can accept the word this cycle
addr  input  ADDR_WIDTH  destination channel index
dout  output  NUM_OUT*DATA_WIDTH  packed outputs; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
dout_valid  output  NUM_OUT  per-channel head-of-FIFO valid
dout_ready  input  NUM_OUT  per-channel consumer ready
full  output  NUM_OUT  per-channel FIFO full flag
drop_cnt  output  16  saturating count of words dropped for out-of-range addr

Behaviour:
- Reset (resetn low, asynchronous): all FIFO pointers and counts go to 0, all FIFO contents are invalid, dout_valid=0, dout=0, full=0, drop_cnt=0. Release is synchronous to clk.
- Reset mid-operation discards all buffered words; nothing is replayed.
- Input accept: a transfer occurs when din_valid && din_ready at the rising edge.
- din_ready = !full[addr] for in-range addr, and 1 for out-of-range addr. It depends only on registered state plus addr, with no combinational path from dout_ready.
- Out-of-range addr (addr >= NUM_OUT, possible only when NUM_OUT is not a power of two): the word is accepted and discarded, and drop_cnt increments, saturating at 16'hFFFF.
- Push: the accepted word is written to FIFO[addr] at the tail, and the tail pointer increments, wrapping modulo FIFO_DEPTH.
- Latency: a word pushed at edge N appears on dout channel addr with dout_valid=1 after edge N (visible in cycle N+1) if that FIFO was empty. There is no same-cycle din-to-dout bypass.
- Pop: channel k pops when dout_valid[k] && dout_ready[k] at the edge, and its head pointer increments with wrap.
- Show-ahead output: dout channel k = head entry when dout_valid[k]=1, else all zeros.
- Once dout_valid[k] is asserted, it and the head data stay stable until popped, independent of dout_ready.
- Occupancy count per channel: width $clog2(FIFO_DEPTH)+1.
  - push only: +1
  - pop only: -1
  - push and pop on the same channel in the same cycle: unchanged, both take effect
- full[k] = (count[k] == FIFO_DEPTH). dout_valid[k] = (count[k] != 0).
- Full boundary: when FIFO k is full, din_ready is low for addr=k even if dout_ready[k]=1 that cycle; the push is accepted one cycle later.
- Channels are fully independent: a full channel never blocks input to a different addr, and pops on multiple channels may occur in the same cycle.
- din, addr and dout_ready values when din_valid=0 have no effect on state.
- At most one push per cycle in total.
- Order within a channel is strict FIFO. There is no ordering guarantee across channels.

Test Plan:
- Reset/idle: assert resetn=0 for 3 cycles with random inputs, then release -> dout=0, dout_valid=0, full=0, drop_cnt=0, din_ready=1.
- Single route: push din=32'hDEADBEEF, addr=2; channel 2 has dout_ready=0 -> next cycle dout_valid=4'b0100, channel 2 reads DEADBEEF, other channels read 0. Raise dout_ready[2] -> word popped, dout_valid=0 next cycle.
- Fill and backpressure: push 1,2,3,4 to addr=1 with dout_ready[1]=0 -> full[1]=1, din_ready=0 for addr=1 and 1 for addr=0. Then drain with dout_ready[1]=1 -> outputs 1,2,3,4 in order, full[1] falls after the first pop.
- Simultaneous push/pop at full: channel 3 holds 4 entries; drive din_valid, addr=3, dout_ready[3]=1 -> no push that cycle (din_ready=0), one pop, count=3. The push is accepted on the next cycle and count returns to 4.
- Wrap-around: 10 interleaved push/pop cycles on channel 0 with values 0..9 -> output sequence 0..9 with no loss or duplication as the pointers wrap at least twice.
- Out-of-range drop (NUM_OUT=3, ADDR_WIDTH=2): push addr=3 five times -> din_ready=1 each cycle, drop_cnt=5, dout_valid stays 3'b000.

Source files
------------

// File: rtl/buffered_router.sv
// buffered_router: routes each accepted input word to one of NUM_OUT output
// channels selected by addr. Every channel owns a FIFO of FIFO_DEPTH entries,
// so a stalled consumer only back-pressures traffic addressed to itself.
//
// Handshake rule for all ports: a word moves on a rising clk edge exactly when
// valid && ready are both high. Once valid is raised, the data stays stable
// until that transfer happens. ready never depends combinationally on the
// valid of the same port. din_ready depends only on registered FIFO state and
// addr. It has no path from dout_ready, so a full channel takes its next push
// one cycle after a pop frees a slot.
module buffered_router #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_OUT    = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(NUM_OUT)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic [ADDR_WIDTH-1:0]         addr,
  output logic [NUM_OUT*DATA_WIDTH-1:0] dout,
  output logic [NUM_OUT-1:0]            dout_valid,
  input  logic [NUM_OUT-1:0]            dout_ready,
  output logic [NUM_OUT-1:0]            full,
  output logic [15:0]                   drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   NUM_OUT_C = (ADDR_WIDTH + 1)'(NUM_OUT);

  logic [DATA_WIDTH-1:0] mem_q   [NUM_OUT][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d   [NUM_OUT][FIFO_DEPTH];
  logic [PTR_W-1:0]      head_q  [NUM_OUT];
  logic [PTR_W-1:0]      head_d  [NUM_OUT];
  logic [PTR_W-1:0]      tail_q  [NUM_OUT];
  logic [PTR_W-1:0]      tail_d  [NUM_OUT];
  logic [CNT_W-1:0]      count_q [NUM_OUT];
  logic [CNT_W-1:0]      count_d [NUM_OUT];
  logic [15:0]           drop_cnt_q;
  logic [15:0]           drop_cnt_d;

  logic                  addr_in_range;
  logic [NUM_OUT-1:0]    push;
  logic [NUM_OUT-1:0]    pop;

  // Status flags, show-ahead outputs and the input-side ready, from registered state.
  always_comb begin
    addr_in_range = ({1'b0, addr} < NUM_OUT_C);
    din_ready     = 1'b1;
    dout          = '0;
    dout_valid    = '0;
    full          = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      full[k]       = (count_q[k] == DEPTH_C);
      dout_valid[k] = (count_q[k] != '0);
      if (dout_valid[k]) begin
        dout[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][head_q[k]];
      end
      // Out-of-range addresses never match a channel, so they stay ready.
      if (addr == ADDR_WIDTH'(k) && full[k]) begin
        din_ready = 1'b0;
      end
    end
    drop_cnt = drop_cnt_q;
  end

  // Next-state for every channel FIFO and the drop counter.
  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    push       = '0;
    pop        = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      push[k] = din_valid && din_ready && (addr == ADDR_WIDTH'(k));
      pop[k]  = dout_valid[k] && dout_ready[k];
      if (push[k]) begin
        mem_d[k][tail_q[k]] = din;
        tail_d[k]           = tail_q[k] + PTR_W'(1);
      end
      if (pop[k]) begin
        head_d[k] = head_q[k] + PTR_W'(1);
      end
      case ({push[k], pop[k]})
        2'b10:   count_d[k] = count_q[k] + CNT_W'(1);
        2'b01:   count_d[k] = count_q[k] - CNT_W'(1);
        default: count_d[k] = count_q[k];
      endcase
    end
    if (din_valid && !addr_in_range && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // State registers; reset empties every FIFO and clears the drop counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q      <= '{default: '0};
      head_q     <= '{default: '0};
      tail_q     <= '{default: '0};
      count_q    <= '{default: '0};
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_buffered_router.sv
// Bench for buffered_router: one 4-channel and one 3-channel instance share the
// same stimulus. A per-channel queue model predicts every output.
module tb_buffered_router;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic [1:0]    addr = '0;
  logic [3:0]    dout_ready = '0;

  logic          din_ready4, din_ready3;
  logic [4*DW-1:0] dout4;
  logic [3*DW-1:0] dout3;
  logic [3:0]    dout_valid4, full4;
  logic [2:0]    dout_valid3, full3;
  logic [15:0]   drop_cnt4, drop_cnt3;

  int checks = 0;
  int errors = 0;

  // Reference model: queue index inst*4+k holds channel k of instance inst.
  logic [DW-1:0] exp_q [8][$];
  int            drops3;

  always #5 clk = ~clk;

  buffered_router #(.DATA_WIDTH(DW), .NUM_OUT(4), .FIFO_DEPTH(DEPTH)) dut4 (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .din_ready(din_ready4), .addr(addr), .dout(dout4), .dout_valid(dout_valid4),
    .dout_ready(dout_ready), .full(full4), .drop_cnt(drop_cnt4)
  );

  buffered_router #(.DATA_WIDTH(DW), .NUM_OUT(3), .FIFO_DEPTH(DEPTH)) dut3 (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .din_ready(din_ready3), .addr(addr), .dout(dout3), .dout_valid(dout_valid3),
    .dout_ready(dout_ready[2:0]), .full(full3), .drop_cnt(drop_cnt3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int n_out(input int inst);
    return (inst == 0) ? 4 : 3;
  endfunction

  function automatic bit model_ready(input int inst);
    if (int'(addr) >= n_out(inst)) return 1'b1;
    return exp_q[inst*4 + int'(addr)].size() < DEPTH;
  endfunction

  task automatic model_reset();
    for (int q = 0; q < 8; q++) exp_q[q].delete();
    drops3 = 0;
  endtask

  // Compare every DUT output against the model's current state.
  task automatic compare_all();
    logic          v, f;
    logic [DW-1:0] d;
    for (int inst = 0; inst < 2; inst++) begin
      for (int k = 0; k < n_out(inst); k++) begin
        int q = inst*4 + k;
        v = (inst == 0) ? dout_valid4[k] : dout_valid3[k];
        f = (inst == 0) ? full4[k] : full3[k];
        d = (inst == 0) ? dout4[k*DW +: DW] : dout3[k*DW +: DW];
        check($sformatf("valid_i%0d_c%0d", inst, k), 64'(v), 64'(exp_q[q].size() != 0));
        check($sformatf("full_i%0d_c%0d", inst, k), 64'(f), 64'(exp_q[q].size() == DEPTH));
        check($sformatf("dout_i%0d_c%0d", inst, k), 64'(d),
              (exp_q[q].size() != 0) ? 64'(exp_q[q][0]) : 64'(0));
      end
    end
    check("din_ready_i0", 64'(din_ready4), 64'(model_ready(0)));
    check("din_ready_i1", 64'(din_ready3), 64'(model_ready(1)));
    check("drop_cnt_i0", 64'(drop_cnt4), 64'(0));
    check("drop_cnt_i1", 64'(drop_cnt3), 64'(drops3));
  endtask

  // One clock: check at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit            pop_m [8];
    bit            push_m [2];
    logic [DW-1:0] d;
    int            a;
    @(negedge clk);
    compare_all();
    d = din;
    a = int'(addr);
    for (int inst = 0; inst < 2; inst++) begin
      for (int k = 0; k < 4; k++)
        pop_m[inst*4+k] = (k < n_out(inst)) && exp_q[inst*4+k].size() > 0 && dout_ready[k];
      push_m[inst] = din_valid && model_ready(inst);
    end
    @(posedge clk);
    #1;
    for (int q = 0; q < 8; q++) if (pop_m[q]) void'(exp_q[q].pop_front());
    for (int inst = 0; inst < 2; inst++) begin
      if (push_m[inst]) begin
        if (a < n_out(inst)) exp_q[inst*4 + a].push_back(d);
        else if (drops3 < 65535) drops3++;
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = $urandom; din_valid = 1'($urandom); addr = 2'($urandom);
      dout_ready = 4'($urandom);
      @(posedge clk);
      #1;
      model_reset();
      compare_all();
    end
    din_valid = 1'b0; dout_ready = '0; addr = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    do_reset();
    check("reset_valid", 64'(dout_valid4), 64'(0));
    check("reset_ready", 64'(din_ready4), 64'(1));

    // Single route to channel 2, then pop it.
    din = 32'hDEADBEEF; addr = 2'd2; din_valid = 1'b1; dout_ready = '0;
    cycle();
    din_valid = 1'b0;
    #1;
    check("route_valid", 64'(dout_valid4), 64'(4'b0100));
    check("route_data", 64'(dout4[2*DW +: DW]), 64'(32'hDEADBEEF));
    check("route_other", 64'(dout4[0 +: DW]), 64'(0));
    dout_ready = 4'b0100;
    cycle();
    check("route_pop", 64'(dout_valid4), 64'(0));

    // Fill channel 1, observe back-pressure, then drain.
    dout_ready = '0; addr = 2'd1;
    for (int i = 1; i <= 4; i++) begin
      din = DW'(i); din_valid = 1'b1;
      cycle();
    end
    #1;
    check("fill_full1", 64'(full4[1]), 64'(1));
    check("fill_rdy1", 64'(din_ready4), 64'(0));
    addr = 2'd0;
    #1;
    check("fill_rdy0", 64'(din_ready4), 64'(1));
    din_valid = 1'b0; dout_ready = 4'b0010;
    check("drain_head", 64'(dout4[DW +: DW]), 64'(1));
    cycle();
    check("drain_full1", 64'(full4[1]), 64'(0));
    idle(3);
    check("drain_empty", 64'(dout_valid4), 64'(0));

    // Push and pop offered together on a full channel 3.
    dout_ready = '0; addr = 2'd3;
    for (int i = 0; i < 4; i++) begin
      din = 32'hA0 + DW'(i); din_valid = 1'b1;
      cycle();
    end
    din = 32'h55; dout_ready = 4'b1000;
    #1;
    check("pp_rdy", 64'(din_ready4), 64'(0));
    cycle();
    check("pp_not_full", 64'(full4[3]), 64'(0));
    dout_ready = '0;
    cycle();
    check("pp_refull", 64'(full4[3]), 64'(1));
    dout_ready = 4'b1111;
    idle(5);

    // Wrap-around on channel 0.
    addr = 2'd0; dout_ready = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      din = DW'(i); din_valid = 1'b1;
      cycle();
    end
    idle(2);

    // Out-of-range drops on the 3-channel instance.
    do_reset();
    addr = 2'd3; dout_ready = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      din = $urandom; din_valid = 1'b1;
      #1;
      check("drop_rdy", 64'(din_ready3), 64'(1));
      cycle();
    end
    din_valid = 1'b0;
    #1;
    check("drop_cnt5", 64'(drop_cnt3), 64'(5));
    check("drop_valid", 64'(dout_valid3), 64'(0));

    // Randomized traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      din        = $urandom;
      din_valid  = ($urandom_range(0, 9) < 7);
      addr       = 2'($urandom_range(0, 3));
      dout_ready = (i < 300) ? 4'($urandom) : 4'($urandom & $urandom);
      if (i == 300) begin
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
      end
      cycle();
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
